hist_bram_scheduler: RTL and testbench

HIST_BRAM_SCHEDULER -- requirements
Module: hist_bram_scheduler

---
 rtl/hist_pkg.sv | 20 ++
 rtl/hist_rd_dly_line.sv | 40 ++++
 rtl/hist_bram_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_hist_bram_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared types for the histogram BRAM scheduler: FSM state encoding and
// bit positions inside the sticky error vector.
// No logic; imported by hist_bram_scheduler and hist_rd_dly_line.
package hist_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR    = 3'd0,
      ST_WAIT_FRM = 3'd1,
      ST_ACCUM    = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_CDF      = 3'd4,
      ST_DONE     = 3'd5
   } hist_state_e;

   localparam int ERR_FSYNC_OVR = 0;  // fsync rose while not ready for a frame
   localparam int ERR_ACC_DROP  = 1;  // accumulator request dropped
   localparam int ERR_SUM_OVF   = 2;  // CDF running sum overflowed
   localparam int ERR_CNT_MIS   = 3;  // final count != pixels per frame

endpackage

// File: rtl/hist_rd_dly_line.sv
// Read-latency tracker: delays a (valid, address) pair by NB_DLY cycles so the
// CDF logic knows which bin the BRAM data belongs to.
// Latency NB_DLY cycles; no backpressure, one entry accepted every cycle.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_vld/i_adr issued
// read; o_vld/o_adr the same read NB_DLY cycles later.
module hist_rd_dly_line
   import hist_pkg::*;
#(
   parameter int NB_DLY = 2,
   parameter int WD_ADR = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_vld,
   input  logic [WD_ADR-1:0] i_adr,
   output logic              o_vld,
   output logic [WD_ADR-1:0] o_adr
);

   logic [NB_DLY-1:0] r_vld;
   logic [WD_ADR-1:0] r_adr [NB_DLY];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < NB_DLY; i++) r_adr[i] <= '0;
      end else begin
         r_vld[0] <= i_vld;
         r_adr[0] <= i_adr;
         for (int i = 1; i < NB_DLY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_adr[i] <= r_adr[i-1];
         end
      end
   end

   assign o_vld = r_vld[NB_DLY-1];
   assign o_adr = r_adr[NB_DLY-1];

endmodule

// File: rtl/hist_bram_scheduler.sv
// Histogram BRAM owner: clears the BRAM, lends it to the accumulator for one
// frame, then streams the CDF out while clearing each bin behind the read.
// Latency: CDF beat k appears NB_BRAM_DLY cycles after its port-B read; no
// backpressure on the CDF stream, and accumulator requests outside a frame are dropped.
// Ports: i_sys_clk/i_sys_resetn clock+reset; s_img_c_fsync frame level;
// s_acc_* accumulator side; m_bram_* dual-port BRAM side; m_cdf_* CDF stream;
// o_busy, o_cdf_done, m_err_info status.
module hist_bram_scheduler
   import hist_pkg::*;
#(
   parameter int NB_BRAM_DLY = 2,
   parameter int WD_BRAM_ADR = 8,
   parameter int WD_BRAM_DAT = 32,
   parameter int NB_IMG_HORI = 960,
   parameter int NB_IMG_VERT = 640,
   parameter int WD_ERR_INFO = 4
) (
   input  logic                   i_sys_clk,
   input  logic                   i_sys_resetn,
   input  logic                   s_img_c_fsync,
   input  logic                   s_acc_ena,
   input  logic                   s_acc_wea,
   input  logic [WD_BRAM_ADR-1:0] s_acc_addra,
   input  logic [WD_BRAM_DAT-1:0] s_acc_dina,
   input  logic                   s_acc_enb,
   input  logic [WD_BRAM_ADR-1:0] s_acc_addrb,
   output logic [WD_BRAM_DAT-1:0] s_acc_doutb,
   output logic                   m_bram_ena,
   output logic                   m_bram_wea,
   output logic [WD_BRAM_ADR-1:0] m_bram_addra,
   output logic [WD_BRAM_DAT-1:0] m_bram_dina,
   output logic                   m_bram_enb,
   output logic [WD_BRAM_ADR-1:0] m_bram_addrb,
   input  logic [WD_BRAM_DAT-1:0] m_bram_doutb,
   output logic                   m_cdf_valid,
   output logic [WD_BRAM_ADR-1:0] m_cdf_addr,
   output logic [WD_BRAM_DAT-1:0] m_cdf_data,
   output logic                   o_busy,
   output logic                   o_cdf_done,
   output logic [WD_ERR_INFO-1:0] m_err_info
);

   localparam int NB_BIN = 2**WD_BRAM_ADR;
   localparam int WD_CNT = WD_BRAM_ADR + 2;
   localparam logic [WD_CNT-1:0] CNT_DRN_END = WD_CNT'(NB_BRAM_DLY + 1);
   localparam logic [WD_CNT-1:0] CNT_CDF_END = WD_CNT'(NB_BIN + NB_BRAM_DLY - 1);
   localparam logic [WD_CNT-1:0] CNT_NB_BIN  = WD_CNT'(NB_BIN);
   localparam logic [WD_BRAM_DAT:0] EXP_CNT  = (WD_BRAM_DAT+1)'(NB_IMG_HORI * NB_IMG_VERT);

   hist_state_e            r_state;
   logic                   r_fsync_q;
   logic [WD_BRAM_ADR-1:0] r_clr_adr;
   logic                   r_clr_wr;
   logic [WD_BRAM_ADR-1:0] r_clr_wadr;
   logic [WD_CNT-1:0]      r_cnt;
   logic [WD_BRAM_DAT:0]   r_sum;
   logic [WD_ERR_INFO-1:0] r_err;

   logic                   w_rise;
   logic                   w_fall;
   logic                   w_acc_sel;
   logic                   w_rd_vld;
   logic                   w_dly_vld;
   logic [WD_BRAM_ADR-1:0] w_dly_adr;
   logic [WD_BRAM_DAT:0]   w_sum_add;
   logic [WD_BRAM_DAT:0]   w_sum_nxt;
   logic                   w_ovr_state;

   assign w_rise    = s_img_c_fsync & ~r_fsync_q;
   assign w_fall    = ~s_img_c_fsync & r_fsync_q;
   assign w_acc_sel = (r_state == ST_ACCUM) || (r_state == ST_DRAIN);
   // CDF reads occupy the first NB_BIN cycles of the CDF state; the remaining
   // NB_BRAM_DLY cycles only collect the trailing read data.
   assign w_rd_vld  = (r_state == ST_CDF) && (r_cnt < CNT_NB_BIN);
   assign w_ovr_state = (r_state == ST_CLEAR) || (r_state == ST_DRAIN) ||
                        (r_state == ST_CDF)   || (r_state == ST_DONE);

   hist_rd_dly_line #(
      .NB_DLY (NB_BRAM_DLY),
      .WD_ADR (WD_BRAM_ADR)
   ) u_rd_dly (
      .i_clk   (i_sys_clk),
      .i_rst_n (i_sys_resetn),
      .i_vld   (w_rd_vld),
      .i_adr   (r_cnt[WD_BRAM_ADR-1:0]),
      .o_vld   (w_dly_vld),
      .o_adr   (w_dly_adr)
   );

   // Once the extra sum bit is set the sum freezes so later adds cannot wrap.
   assign w_sum_add = r_sum + {1'b0, m_bram_doutb};
   assign w_sum_nxt = r_sum[WD_BRAM_DAT] ? r_sum : w_sum_add;

   assign m_cdf_valid = w_dly_vld;
   assign m_cdf_addr  = w_dly_adr;
   assign m_cdf_data  = w_sum_nxt[WD_BRAM_DAT] ? '1 : w_sum_nxt[WD_BRAM_DAT-1:0];
   assign o_busy      = !((r_state == ST_WAIT_FRM) || (r_state == ST_ACCUM));
   assign o_cdf_done  = (r_state == ST_DONE);
   assign m_err_info  = r_err;
   assign s_acc_doutb = w_acc_sel ? m_bram_doutb : '0;

   always_comb begin
      m_bram_ena   = 1'b0;
      m_bram_wea   = 1'b0;
      m_bram_addra = '0;
      m_bram_dina  = '0;
      m_bram_enb   = 1'b0;
      m_bram_addrb = '0;
      if (w_acc_sel) begin
         m_bram_ena   = s_acc_ena;
         m_bram_wea   = s_acc_wea;
         m_bram_addra = s_acc_addra;
         m_bram_dina  = s_acc_dina;
         m_bram_enb   = s_acc_enb;
         m_bram_addrb = s_acc_addrb;
      end else begin
         // Clear writes and read-then-clear writes never overlap in time.
         if (r_clr_wr) begin
            m_bram_ena   = 1'b1;
            m_bram_wea   = 1'b1;
            m_bram_addra = r_clr_wadr;
         end else if (w_dly_vld) begin
            m_bram_ena   = 1'b1;
            m_bram_wea   = 1'b1;
            m_bram_addra = w_dly_adr;
         end
         m_bram_enb   = w_rd_vld;
         m_bram_addrb = w_rd_vld ? r_cnt[WD_BRAM_ADR-1:0] : '0;
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
      if (!i_sys_resetn) begin
         r_state    <= ST_CLEAR;
         r_fsync_q  <= 1'b0;
         r_clr_adr  <= '0;
         r_clr_wr   <= 1'b0;
         r_clr_wadr <= '0;
         r_cnt      <= '0;
         r_sum      <= '0;
         r_err      <= '0;
      end else begin
         r_fsync_q <= s_img_c_fsync;
         r_clr_wr  <= 1'b0;

         if (w_rise && w_ovr_state) r_err[ERR_FSYNC_OVR] <= 1'b1;
         if (!w_acc_sel && (s_acc_ena || s_acc_enb)) r_err[ERR_ACC_DROP] <= 1'b1;
         if (w_dly_vld) begin
            r_sum <= w_sum_nxt;
            if (w_sum_nxt[WD_BRAM_DAT]) r_err[ERR_SUM_OVF] <= 1'b1;
         end

         case (r_state)
            ST_CLEAR: begin
               r_clr_wr   <= 1'b1;
               r_clr_wadr <= r_clr_adr;
               r_clr_adr  <= r_clr_adr + 1'b1;
               if (r_clr_adr == '1) r_state <= ST_WAIT_FRM;
            end
            ST_WAIT_FRM: begin
               if (w_rise) r_state <= ST_ACCUM;
            end
            ST_ACCUM: begin
               if (w_fall) begin
                  r_state <= ST_DRAIN;
                  r_cnt   <= '0;
               end
            end
            ST_DRAIN: begin
               // Lets the accumulator's last read-modify-write land.
               if (r_cnt == CNT_DRN_END) begin
                  r_state <= ST_CDF;
                  r_cnt   <= '0;
                  r_sum   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_CDF: begin
               if (r_cnt == CNT_CDF_END) r_state <= ST_DONE;
               else                      r_cnt   <= r_cnt + 1'b1;
            end
            ST_DONE: begin
               if (r_sum != EXP_CNT) r_err[ERR_CNT_MIS] <= 1'b1;
               r_state <= ST_WAIT_FRM;
            end
            default: r_state <= ST_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_hist_bram_scheduler.sv
module tb_hist_bram_scheduler;

   localparam int D    = 2;
   localparam int WA   = 8;
   localparam int WD   = 32;
   localparam int HORI = 4;
   localparam int VERT = 2;
   localparam int WE   = 4;
   localparam int NB   = 256;
   localparam int NPIX = HORI * VERT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          fsync;
   logic          s_acc_ena, s_acc_wea, s_acc_enb;
   logic [WA-1:0] s_acc_addra, s_acc_addrb;
   logic [WD-1:0] s_acc_dina, s_acc_doutb;
   logic          m_bram_ena, m_bram_wea, m_bram_enb;
   logic [WA-1:0] m_bram_addra, m_bram_addrb;
   logic [WD-1:0] m_bram_dina, m_bram_doutb;
   logic          m_cdf_valid;
   logic [WA-1:0] m_cdf_addr;
   logic [WD-1:0] m_cdf_data;
   logic          o_busy, o_cdf_done;
   logic [WE-1:0] m_err_info;

   hist_bram_scheduler #(
      .NB_BRAM_DLY(D), .WD_BRAM_ADR(WA), .WD_BRAM_DAT(WD),
      .NB_IMG_HORI(HORI), .NB_IMG_VERT(VERT), .WD_ERR_INFO(WE)
   ) dut (
      .i_sys_clk(clk), .i_sys_resetn(rst_n), .s_img_c_fsync(fsync),
      .s_acc_ena(s_acc_ena), .s_acc_wea(s_acc_wea), .s_acc_addra(s_acc_addra),
      .s_acc_dina(s_acc_dina), .s_acc_enb(s_acc_enb), .s_acc_addrb(s_acc_addrb),
      .s_acc_doutb(s_acc_doutb),
      .m_bram_ena(m_bram_ena), .m_bram_wea(m_bram_wea), .m_bram_addra(m_bram_addra),
      .m_bram_dina(m_bram_dina), .m_bram_enb(m_bram_enb), .m_bram_addrb(m_bram_addrb),
      .m_bram_doutb(m_bram_doutb),
      .m_cdf_valid(m_cdf_valid), .m_cdf_addr(m_cdf_addr), .m_cdf_data(m_cdf_data),
      .o_busy(o_busy), .o_cdf_done(o_cdf_done), .m_err_info(m_err_info)
   );

   // Dual-port BRAM with D-cycle read latency, read-first.
   logic [WD-1:0] mem [NB];
   logic [WD-1:0] rd_pipe [D];
   always @(posedge clk) begin
      if (m_bram_ena && m_bram_wea) mem[m_bram_addra] <= m_bram_dina;
      if (m_bram_enb) rd_pipe[0] <= mem[m_bram_addrb];
      for (int i = 1; i < D; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign m_bram_doutb = rd_pipe[D-1];

   // Latency-sweep instances, BRAM data irrelevant so read data is tied to zero.
   logic          x1_ena, x1_wea, x1_enb, x1_vld, x1_busy, x1_done;
   logic [WA-1:0] x1_adra, x1_adrb, x1_cadr;
   logic [WD-1:0] x1_dina, x1_dat, x1_adout;
   logic [WE-1:0] x1_err;
   logic          x4_ena, x4_wea, x4_enb, x4_vld, x4_busy, x4_done;
   logic [WA-1:0] x4_adra, x4_adrb, x4_cadr;
   logic [WD-1:0] x4_dina, x4_dat, x4_adout;
   logic [WE-1:0] x4_err;

   hist_bram_scheduler #(
      .NB_BRAM_DLY(1), .WD_BRAM_ADR(WA), .WD_BRAM_DAT(WD),
      .NB_IMG_HORI(HORI), .NB_IMG_VERT(VERT), .WD_ERR_INFO(WE)
   ) dut_d1 (
      .i_sys_clk(clk), .i_sys_resetn(rst_n), .s_img_c_fsync(fsync),
      .s_acc_ena(1'b0), .s_acc_wea(1'b0), .s_acc_addra('0), .s_acc_dina('0),
      .s_acc_enb(1'b0), .s_acc_addrb('0), .s_acc_doutb(x1_adout),
      .m_bram_ena(x1_ena), .m_bram_wea(x1_wea), .m_bram_addra(x1_adra),
      .m_bram_dina(x1_dina), .m_bram_enb(x1_enb), .m_bram_addrb(x1_adrb),
      .m_bram_doutb('0),
      .m_cdf_valid(x1_vld), .m_cdf_addr(x1_cadr), .m_cdf_data(x1_dat),
      .o_busy(x1_busy), .o_cdf_done(x1_done), .m_err_info(x1_err)
   );

   hist_bram_scheduler #(
      .NB_BRAM_DLY(4), .WD_BRAM_ADR(WA), .WD_BRAM_DAT(WD),
      .NB_IMG_HORI(HORI), .NB_IMG_VERT(VERT), .WD_ERR_INFO(WE)
   ) dut_d4 (
      .i_sys_clk(clk), .i_sys_resetn(rst_n), .s_img_c_fsync(fsync),
      .s_acc_ena(1'b0), .s_acc_wea(1'b0), .s_acc_addra('0), .s_acc_dina('0),
      .s_acc_enb(1'b0), .s_acc_addrb('0), .s_acc_doutb(x4_adout),
      .m_bram_ena(x4_ena), .m_bram_wea(x4_wea), .m_bram_addra(x4_adra),
      .m_bram_dina(x4_dina), .m_bram_enb(x4_enb), .m_bram_addrb(x4_adrb),
      .m_bram_doutb('0),
      .m_cdf_valid(x4_vld), .m_cdf_addr(x4_cadr), .m_cdf_data(x4_dat),
      .o_busy(x4_busy), .o_cdf_done(x4_done), .m_err_info(x4_err)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // First read issue / first CDF beat of the sweep instances.
   int x1_rd = -1, x1_vl = -1, x4_rd = -1, x4_vl = -1;
   always @(negedge clk) begin
      if (x1_rd < 0 && x1_enb) x1_rd = cyc;
      if (x1_vl < 0 && x1_vld) x1_vl = cyc;
      if (x4_rd < 0 && x4_enb) x4_rd = cyc;
      if (x4_vl < 0 && x4_vld) x4_vl = cyc;
   end

   // CDF stream capture for the main instance.
   logic [WA-1:0] q_adr [$];
   logic [WD-1:0] q_dat [$];
   int done_cnt = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_cdf_valid) begin
            q_adr.push_back(m_cdf_addr);
            q_dat.push_back(m_cdf_data);
         end
         if (o_cdf_done) done_cnt++;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: histogram of the frame, then its running sum.
   int            pix [NPIX];
   logic [WD-1:0] exp_cdf [NB];
   longint        exp_total;

   task automatic build_model(input int extra);
      longint hist [NB];
      longint run;
      for (int k = 0; k < NB; k++) hist[k] = 0;
      for (int p = 0; p < NPIX; p++) hist[pix[p]] += 1;
      hist[pix[0]] += extra;
      run = 0;
      for (int k = 0; k < NB; k++) begin
         run += hist[k];
         exp_cdf[k] = (run > 64'hFFFF_FFFF) ? '1 : run[WD-1:0];
      end
      exp_total = run;
   endtask

   function automatic int mem_nonzero();
      int n = 0;
      for (int i = 0; i < NB; i++) if (mem[i] !== '0) n++;
      return n;
   endfunction

   // One histogram read-modify-write through the DUT.
   task automatic acc_pixel(input int bin, input int inc);
      logic [WD-1:0] v;
      s_acc_enb   = 1'b1;
      s_acc_addrb = WA'(bin);
      tick();
      s_acc_enb = 1'b0;
      repeat (D - 1) tick();
      v = s_acc_doutb;
      s_acc_ena   = 1'b1;
      s_acc_wea   = 1'b1;
      s_acc_addra = WA'(bin);
      s_acc_dina  = v + WD'(inc);
      tick();
      s_acc_ena = 1'b0;
      s_acc_wea = 1'b0;
   endtask

   task automatic frame_accum(input int extra);
      fsync = 1'b1;
      repeat (3) tick();
      for (int p = 0; p < NPIX; p++) acc_pixel(pix[p], (p == 0) ? 1 + extra : 1);
      tick();
      fsync = 1'b0;
      tick();
   endtask

   task automatic check_cdf(input int base, input int start_done, input logic [WE-1:0] exp_err);
      int bad, last;
      for (int i = 0; i < 2000 && done_cnt == start_done; i++) tick();
      repeat (4) tick();
      chk("done_pulses", 64'(done_cnt - start_done), 64'd1);
      chk("cdf_beats", 64'(q_adr.size() - base), 64'(NB));
      bad = 0;
      for (int k = 0; k < NB; k++) begin
         if (base + k < q_adr.size()) begin
            if (q_adr[base+k] !== WA'(k) || q_dat[base+k] !== exp_cdf[k]) bad++;
         end else begin
            bad++;
         end
      end
      chk("cdf_beat_errors", 64'(bad), 64'd0);
      last = (q_dat.size() > 0) ? q_dat.size() - 1 : 0;
      chk("cdf_final_sum", (q_dat.size() > base) ? 64'(q_dat[last]) : 64'hDEAD, 64'(exp_total));
      chk("err_info", 64'(m_err_info), 64'(exp_err));
      chk("bram_zero_after_cdf", 64'(mem_nonzero()), 64'd0);
      chk("busy_idle", 64'(o_busy), 64'd0);
   endtask

   logic [WE-1:0] exp_err;
   int base, sd, n, leak;

   initial begin
      rst_n = 1'b0; fsync = 1'b0;
      s_acc_ena = 1'b0; s_acc_wea = 1'b0; s_acc_enb = 1'b0;
      s_acc_addra = '0; s_acc_addrb = '0; s_acc_dina = '0;
      exp_err = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_busy", 64'(o_busy), 64'd1);
      chk("rst_cdf_valid", 64'(m_cdf_valid), 64'd0);
      chk("rst_cdf_done", 64'(o_cdf_done), 64'd0);
      chk("rst_err", 64'(m_err_info), 64'd0);
      chk("rst_bram_outs", 64'({m_bram_ena, m_bram_wea, m_bram_enb, m_bram_addra, m_bram_addrb, m_bram_dina}), 64'd0);

      // Initial clear: 256 cycles of busy
      rst_n = 1'b1;
      n = 0;
      while (o_busy && n < 400) begin tick(); n++; end
      chk("clear_len", 64'(n), 64'(NB));
      tick();
      chk("bram_zero_after_clear", 64'(mem_nonzero()), 64'd0);

      // 4x2 frame of 0x10 pixels
      for (int p = 0; p < NPIX; p++) pix[p] = 16;
      build_model(0);
      base = q_adr.size(); sd = done_cnt;
      frame_accum(0);
      check_cdf(base, sd, exp_err);
      chk("bin15_zero", 64'(q_dat[base+15]), 64'd0);
      chk("bin16_eight", 64'(q_dat[base+16]), 64'd8);

      // fsync rises during CDF: flagged, stream unaffected
      for (int p = 0; p < NPIX; p++) pix[p] = int'($urandom_range(0, NB - 1));
      build_model(0);
      base = q_adr.size(); sd = done_cnt;
      frame_accum(0);
      for (int i = 0; i < 500 && q_adr.size() <= base; i++) tick();
      fsync = 1'b1;
      exp_err[0] = 1'b1;
      check_cdf(base, sd, exp_err);
      fsync = 1'b0;
      repeat (3) tick();

      // Next clean frame, random bins
      for (int p = 0; p < NPIX; p++) pix[p] = int'($urandom_range(0, NB - 1));
      build_model(0);
      base = q_adr.size(); sd = done_cnt;
      frame_accum(0);
      check_cdf(base, sd, exp_err);

      // Five extra counts: total 13, count mismatch flagged
      for (int p = 0; p < NPIX; p++) pix[p] = int'($urandom_range(0, NB - 1));
      build_model(5);
      base = q_adr.size(); sd = done_cnt;
      frame_accum(5);
      exp_err[3] = 1'b1;
      check_cdf(base, sd, exp_err);
      chk("final_13", 64'(q_dat[q_dat.size()-1]), 64'd13);

      // Read-latency sweep
      chk("d1_read_seen", 64'(x1_rd >= 0), 64'd1);
      chk("d1_latency", 64'(x1_vl - x1_rd), 64'd1);
      chk("d4_read_seen", 64'(x4_rd >= 0), 64'd1);
      chk("d4_latency", 64'(x4_vl - x4_rd), 64'd4);

      // Reset mid-CDF, then accumulator requests during the re-run clear
      for (int p = 0; p < NPIX; p++) pix[p] = int'($urandom_range(0, NB - 1));
      pix[NPIX-1] = 200;
      base = q_adr.size();
      frame_accum(0);
      for (int i = 0; i < 500 && q_adr.size() <= base + 20; i++) tick();
      rst_n = 1'b0;
      tick();
      chk("rst2_busy", 64'(o_busy), 64'd1);
      chk("rst2_cdf_valid", 64'(m_cdf_valid), 64'd0);
      chk("rst2_err", 64'(m_err_info), 64'd0);
      s_acc_ena = 1'b1; s_acc_wea = 1'b1; s_acc_addra = 8'd5; s_acc_dina = 32'hDEAD;
      tick();
      rst_n = 1'b1;
      n = 0; leak = 0;
      while (o_busy && n < 400) begin
         if (m_bram_ena && m_bram_wea && m_bram_dina !== '0) leak++;
         tick();
         n++;
      end
      s_acc_ena = 1'b0; s_acc_wea = 1'b0; s_acc_dina = '0;
      repeat (2) tick();
      chk("clear2_len", 64'(n), 64'(NB));
      chk("clear_no_leak", 64'(leak), 64'd0);
      chk("err_acc_drop", 64'(m_err_info), 64'h2);
      chk("bram_zero_after_reclear", 64'(mem_nonzero()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
